cpu_bus_responder: RTL
======================

Name: cpu_bus_responder

Overview:
- Responder end of the 6502 CPU bus. Watches the CPU's `addr` and `rw` lines and owns the shared `data` line.
- Serves the 2 KiB internal work RAM, mirrored across $0000-$1FFF.
- Serves the two serial controller ports at $4016/$4017, including the strobe latch and shift registers.
- Flags every other address on `ext_sel` so PPU, APU and cartridge blocks can decode it.

Parameters:
- RAM_AW, 11, work-RAM address width (2^RAM_AW bytes), mirrored over $0000-$1FFF.
- RESET_DATA, 8'h00, reset value of the read-data register and the bus latch.

Ports:
- clk  input  1  system clock; CPU updates the bus on negedge, this block acts on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rw  input  1  CPU bus direction: 1 = read, 0 = write.
- addr  input  16  CPU address.
- data  inout  8  CPU data bus; driven by this block only while `rw`=1 and a drive is enabled.
- pad1  input  8  controller 1 buttons, bit0=A ... bit7=Right, 1=pressed.
- pad2  input  8  controller 2 buttons, same ordering.
- ext_sel  output  1  combinational; 1 when `addr` is outside this block's map.
- strobe  output  1  current controller strobe latch, for debug and pads.

Behaviour:
- One bus cycle per clk period. Sample `addr`, `rw` and `data` on posedge. Each posedge is exactly one transaction, so read side effects occur once per posedge.
- Address map:
  - RAM hit: `addr` < $2000; RAM index = `addr[RAM_AW-1:0]`.
  - PAD1 hit: $4016. PAD2 hit: $4017.
  - `ext_sel` = 1 for any other address.
- Write cycle (`rw`=0):
  - RAM hit: write `data` to RAM at posedge.
  - $4016: `strobe` <= `data[0]`.
  - $4017 and unmapped addresses: ignored by this block.
- Read cycle (`rw`=1):
  - `rdata` is registered at posedge from the pre-edge state.
  - `drive_en` <= 1 if mapped, else 0.
  - `data` = (`drive_en` && `rw`) ? `rdata` : 8'bz. Gating with live `rw` prevents contention when the CPU turns the bus at negedge.
  - Latency: value visible half a cycle after the sampling posedge, so it is valid at the CPU's next negedge.
- Read data:
  - RAM: the stored byte.
  - $4016/$4017: {7'b0, bit}. If `strobe`=1, bit = pad bit0 (live A button). If `strobe`=0, bit = shift register bit0.
- Shift registers sh1, sh2 (8 bits each):
  - Reload from pad1/pad2 on any posedge where `strobe`=1 or a $4016 write carries `data[0]`=1.
  - Otherwise, a read of $4016 shifts sh1 <= {1'b1, sh1[7:1]}; a read of $4017 does the same to sh2.
  - After 8 shifts, reads return 1 indefinitely.
- Simultaneous write $4016 with `data[0]`=0 while `strobe`=1: reload still happens on that edge, and `strobe` clears. The next read returns A.
- Reset (async, any time, including mid-transaction):
  - `strobe`=0, sh1=sh2=8'hFF, `rdata`=RESET_DATA, `drive_en`=0, bus latch=RESET_DATA, `data` released (z).
  - RAM contents are not reset.
  - `ext_sel` stays combinational and is unaffected by reset.
- No accesses are lost at the mirror wrap: $07FF, $0800, $1FFF alias RAM indices 7FF, 000, 7FF.

Optional Feature:
- Macro OPEN_BUS_EN.
- When defined:
  - Maintain an 8-bit bus latch, updated every posedge. On a write it takes `data`; on a mapped read it takes the read value.
  - Unmapped reads drive `data` with the latch (`drive_en`=1 even when `ext_sel`=1).
  - Controller reads return {latch[7:1], bit}.
- When undefined:
  - No latch.
  - Unmapped reads leave `data` at z.
  - Controller upper bits are 0.

Test Plan:
- Reset mid-read: assert `rst_n`=0 while `rw`=1, `addr`=$0000 -> `data` goes z immediately, `strobe`=0; after release, a $4016 read returns 8'h01 (sh1=FF).
- Mirroring: write 8'hA5 to $0812 -> reads of $0012, $1012, $1812 each return 8'hA5 at the following negedge; `ext_sel`=0 throughout.
- Controller serial read: pad1=8'b1000_0101; write $4016=1 then $4016=0; 10 reads of $4016 -> bit0 sequence 1,0,1,0,0,0,0,1,1,1.
- Strobe held high: `strobe`=1, pad1 toggles bit0 between reads -> each $4016 read tracks live A; sh1 is not shifted.
- Unmapped and contention: read $2002 -> `ext_sel`=1, `data`=z without OPEN_BUS_EN. With OPEN_BUS_EN after a write of 8'h3C anywhere, the same read returns 8'h3C. A write cycle directly after a RAM read sees no drive from this block once `rw`=0.
- Port 2 independence: pad2=8'hFF, pad1=8'h00, strobe pulse; 3 reads of $4017 return 1s while a following $4016 read returns 0.

Source files
------------

// File: rtl/cpu_bus_responder_if.sv
// rtl/cpu_bus_responder_if.sv - CPU address/direction bus bundle for the responder
//
// Purpose: carries the CPU-owned address and direction lines plus the
// responder's combinational "not mine" decode back to the CPU side.
// The shared 8-bit data line is kept as a plain inout on the responder so
// that tristate resolution stays on an ordinary net.
//
// Signals:
//   rw       CPU direction, 1 = read, 0 = write (driven by master)
//   addr     16-bit CPU address (driven by master)
//   ext_sel  1 when addr falls outside the responder's map (driven by slave)
//
// Modports:
//   master  CPU / testbench side
//   slave   cpu_bus_responder side

interface cpu_bus_responder_if;
  logic        rw;
  logic [15:0] addr;
  logic        ext_sel;

  modport master (
    output rw,
    output addr,
    input  ext_sel
  );

  modport slave (
    input  rw,
    input  addr,
    output ext_sel
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - 6502 bus responder: work RAM, controller ports, external decode
//
// Purpose: answers the CPU for the mirrored 2 KiB work RAM ($0000-$1FFF)
// and the two serial controller ports ($4016/$4017). Every other address is
// flagged on ext_sel for downstream decoders. One bus transaction per clk
// posedge; the CPU moves the bus on negedge.
//
// Optional build macro: OPEN_BUS_EN
//   defined   - an 8-bit bus latch remembers the last value on the bus;
//               unmapped reads return it and controller reads carry its
//               upper seven bits.
//   undefined - no latch; unmapped reads leave data released, controller
//               upper bits read as 0.
//
// Parameters:
//   RAM_AW      work-RAM address width (2^RAM_AW bytes)
//   RESET_DATA  reset value of the read-data register and bus latch
//
// Ports:
//   clk     system clock (this block acts on posedge)
//   rst_n   asynchronous active-low reset
//   bus     cpu_bus_responder_if.slave: rw, addr in; ext_sel out
//   data    8-bit shared CPU data bus (inout)
//   pad1    controller 1 buttons, bit0 = A ... bit7 = Right, 1 = pressed
//   pad2    controller 2 buttons, same ordering
//   strobe  current controller strobe latch

module cpu_bus_responder #(
  parameter int          RAM_AW     = 11,
  parameter logic [7:0]  RESET_DATA = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cpu_bus_responder_if.slave   bus,
  inout  wire  [7:0]           data,
  input  logic [7:0]           pad1,
  input  logic [7:0]           pad2,
  output logic                 strobe
);

  localparam logic [15:0] RAM_END   = 16'h2000;
  localparam logic [15:0] PAD1_ADDR = 16'h4016;
  localparam logic [15:0] PAD2_ADDR = 16'h4017;
  localparam int          RAM_DEPTH = 1 << RAM_AW;

  // ---------------------------------------------------------------------
  // Address decode (purely combinational, independent of reset)
  // ---------------------------------------------------------------------
  logic ram_hit;
  logic pad1_hit;
  logic pad2_hit;
  logic mapped;

  always_comb begin
    ram_hit  = (bus.addr < RAM_END);
    pad1_hit = (bus.addr == PAD1_ADDR);
    pad2_hit = (bus.addr == PAD2_ADDR);
    mapped   = ram_hit | pad1_hit | pad2_hit;
  end

  assign bus.ext_sel = ~mapped;

  // Low address bits select the RAM byte; upper bits below $2000 only
  // mirror the same storage.
  logic [RAM_AW-1:0] ram_idx;
  assign ram_idx = bus.addr[RAM_AW-1:0];

  logic write_cyc;
  logic read_cyc;
  assign write_cyc = ~bus.rw;
  assign read_cyc  = bus.rw;

  // ---------------------------------------------------------------------
  // Work RAM (contents survive reset)
  // ---------------------------------------------------------------------
  logic [7:0] mem [RAM_DEPTH];
  logic [7:0] ram_q;

  assign ram_q = mem[ram_idx];

  always_ff @(posedge clk) begin
    if (write_cyc && ram_hit) begin
      mem[ram_idx] <= data;
    end
  end

  // ---------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------
  logic [7:0] sh1;
  logic [7:0] sh2;
  logic [7:0] rdata;
  logic       drive_en;

`ifdef OPEN_BUS_EN
  logic [7:0] bus_latch;
  logic [6:0] pad_upper;
  assign pad_upper = bus_latch[7:1];
`else
  logic [6:0] pad_upper;
  assign pad_upper = 7'b0;
`endif

  // ---------------------------------------------------------------------
  // Controller serial logic
  // ---------------------------------------------------------------------
  // While strobe is high the port reports the live A button; otherwise it
  // reports the head of the shift register.
  logic pad1_bit;
  logic pad2_bit;
  assign pad1_bit = strobe ? pad1[0] : sh1[0];
  assign pad2_bit = strobe ? pad2[0] : sh2[0];

  // Reload is driven by the strobe level seen before this edge, so a write
  // of 0 to $4016 while strobe is high still reloads on that same edge.
  logic strobe_wr;
  logic reload;
  assign strobe_wr = write_cyc & pad1_hit;
  assign reload    = strobe | (strobe_wr & data[0]);

  logic [7:0] sh1_next;
  logic [7:0] sh2_next;

  always_comb begin
    sh1_next = sh1;
    sh2_next = sh2;
    if (reload) begin
      sh1_next = pad1;
      sh2_next = pad2;
    end else begin
      // Shifting in ones makes an exhausted register read 1 forever.
      if (read_cyc && pad1_hit) begin
        sh1_next = {1'b1, sh1[7:1]};
      end
      if (read_cyc && pad2_hit) begin
        sh2_next = {1'b1, sh2[7:1]};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read value selection (from pre-edge state)
  // ---------------------------------------------------------------------
  logic [7:0] rd_value;

  always_comb begin
    // Unmapped reads keep the previous register contents unless the bus
    // latch supplies an open-bus value.
    rd_value = rdata;
    if (ram_hit) begin
      rd_value = ram_q;
    end else if (pad1_hit) begin
      rd_value = {pad_upper, pad1_bit};
    end else if (pad2_hit) begin
      rd_value = {pad_upper, pad2_bit};
    end else begin
`ifdef OPEN_BUS_EN
      rd_value = bus_latch;
`else
      rd_value = rdata;
`endif
    end
  end

  logic drive_next;
`ifdef OPEN_BUS_EN
  assign drive_next = read_cyc;
`else
  assign drive_next = read_cyc & mapped;
`endif

  // ---------------------------------------------------------------------
  // Sequential update
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe   <= 1'b0;
      sh1      <= 8'hFF;
      sh2      <= 8'hFF;
      rdata    <= RESET_DATA;
      drive_en <= 1'b0;
    end else begin
      if (strobe_wr) begin
        strobe <= data[0];
      end
      sh1      <= sh1_next;
      sh2      <= sh2_next;
      drive_en <= drive_next;
      if (read_cyc) begin
        rdata <= rd_value;
      end
    end
  end

`ifdef OPEN_BUS_EN
  // The latch tracks whatever last appeared on the bus: the CPU's value on
  // writes, this block's answer on reads (unmapped reads re-drive it).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_latch <= RESET_DATA;
    end else if (write_cyc) begin
      bus_latch <= data;
    end else begin
      bus_latch <= rd_value;
    end
  end
`endif

  // Gating with the live rw releases the bus the moment the CPU turns it
  // for a write, before the next posedge clears drive_en.
  assign data = (drive_en && bus.rw) ? rdata : 8'bz;

endmodule
